// File: rtl/ring_phase_monitor.sv
// Watches a one-hot ring counter: decodes its phase, tracks lock on clean
// single-position advances, latches faults and counts completed revolutions.
module ring_phase_monitor #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 4,
  parameter int REV_W    = 8,
  localparam int PW      = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW      = $clog2(LOCK_CNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_ring_in,
  input  logic             i_clr_fault,
  output logic [PW-1:0]    o_phase,
  output logic             o_phase_valid,
  output logic             o_locked,
  output logic             o_fault,
  output logic [REV_W-1:0] o_rev_count,
  output logic             o_rev_tick
);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_LOCKED, S_FAULT} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_prev;
  logic [PW-1:0]      r_phase;
  logic               r_phase_valid;
  logic               r_locked;
  logic               r_fault;
  logic [REV_W-1:0]   r_rev_count;
  logic               r_rev_tick;

  state_t             w_nxt_state;
  logic [CW-1:0]      w_nxt_cnt;
  logic [PW:0]        w_ones;
  logic [PW-1:0]      w_idx;
  logic               w_onehot;
  logic [WIDTH-1:0]   w_rot;
  logic               w_step_ok;
  logic               w_rev_hit;

  // Population count and hot-bit index share one scan of the input.
  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_ring_in[i]) begin
        w_ones = w_ones + {{PW{1'b0}}, 1'b1};
        w_idx  = PW'(i);
      end
    end
  end

  assign w_onehot  = (w_ones == {{PW{1'b0}}, 1'b1});
  assign w_rot     = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
  assign w_step_ok = w_onehot && (i_ring_in == w_rot);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_rev_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_nxt_state = S_TRACK;
          w_nxt_cnt   = '0;
        end
      end
      S_TRACK: begin
        if (w_step_ok) begin
          if (r_cnt == CW'(LOCK_CNT - 1)) w_nxt_state = S_LOCKED;
          else                            w_nxt_cnt   = r_cnt + CW'(1);
        end else begin
          w_nxt_cnt = '0;
          if (!w_onehot) w_nxt_state = S_IDLE;
        end
      end
      S_LOCKED: begin
        // A revolution completes when a clean step lands back on bit 0.
        if (w_step_ok) w_rev_hit   = i_ring_in[0];
        else           w_nxt_state = S_FAULT;
      end
      S_FAULT: begin
        if (i_clr_fault) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_prev        <= '0;
      r_phase       <= '0;
      r_phase_valid <= 1'b0;
      r_locked      <= 1'b0;
      r_fault       <= 1'b0;
      r_rev_count   <= '0;
      r_rev_tick    <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_prev        <= i_ring_in;
      r_phase_valid <= w_onehot;
      if (w_onehot) r_phase <= w_idx;
      r_locked      <= (w_nxt_state == S_LOCKED);
      r_fault       <= (w_nxt_state == S_FAULT);
      r_rev_tick    <= w_rev_hit;
      if (w_rev_hit) r_rev_count <= r_rev_count + REV_W'(1);
    end
  end

  assign o_phase       = r_phase;
  assign o_phase_valid = r_phase_valid;
  assign o_locked      = r_locked;
  assign o_fault       = r_fault;
  assign o_rev_count   = r_rev_count;
  assign o_rev_tick    = r_rev_tick;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed plus randomized stimulus for ring_phase_monitor, checked every
// cycle against a behavioural model of the ring-tracking rules.
module tb_ring_phase_monitor;

  localparam int W  = 4;
  localparam int LC = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  ring = 4'b0001;
  logic          clr_fault = 1'b0;
  logic [1:0]    phase;
  logic          phase_valid, locked, fault, rev_tick;
  logic [RW-1:0] rev_count;

  ring_phase_monitor #(.WIDTH(W), .LOCK_CNT(LC), .REV_W(RW)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ring_in    (ring),
    .i_clr_fault  (clr_fault),
    .o_phase      (phase),
    .o_phase_valid(phase_valid),
    .o_locked     (locked),
    .o_fault      (fault),
    .o_rev_count  (rev_count),
    .o_rev_tick   (rev_tick)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 tracking, 2 locked, 3 faulted.
  int m_mode = 0, m_good = 0, m_prev = 0, m_phase = 0, m_pv = 0, m_rev = 0, m_tick = 0;
  int p = 0;
  logic [W-1:0] last_r = 4'b0001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_edge(input int r, input bit clr, input bit rs);
    bit oh, ok;
    int want;
    if (rs) begin
      m_mode = 0; m_good = 0; m_prev = 0; m_phase = 0; m_pv = 0; m_rev = 0; m_tick = 0;
      return;
    end
    oh   = ($countones(r[W-1:0]) == 1);
    want = (m_prev * 2) % (1 << W) + m_prev / (1 << (W - 1));
    ok   = oh && (r == want);
    m_tick = 0;
    case (m_mode)
      0: if (oh) begin m_mode = 1; m_good = 0; end
      1: if (ok) begin
           if (m_good + 1 == LC) m_mode = 2; else m_good++;
         end else begin
           m_good = 0;
           if (!oh) m_mode = 0;
         end
      2: if (ok) begin
           if (r == 1) begin m_rev = (m_rev + 1) % (1 << RW); m_tick = 1; end
         end else m_mode = 3;
      default: if (clr) begin m_mode = 0; m_good = 0; end
    endcase
    m_pv = oh;
    if (oh) m_phase = $clog2(r);
    m_prev = r;
  endtask

  task automatic step(input logic [W-1:0] r, input logic clr, input logic rs);
    @(negedge clk);
    ring = r; clr_fault = clr; rst = rs; last_r = r;
    @(posedge clk);
    model_edge(int'(r), clr, rs);
    #1;
    check("phase",       32'(phase),       32'(m_phase));
    check("phase_valid", 32'(phase_valid), 32'(m_pv));
    check("locked",      32'(locked),      32'(m_mode == 2));
    check("fault",       32'(fault),       32'(m_mode == 3));
    check("rev_count",   32'(rev_count),   32'(m_rev));
    check("rev_tick",    32'(rev_tick),    32'(m_tick));
  endtask

  task automatic run(input int n);
    logic [W-1:0] r;
    repeat (n) begin
      r = 4'b0001 << p;
      step(r, 1'b0, 1'b0);
      p = (p + 1) % W;
    end
  endtask

  initial begin
    logic [W-1:0] r;
    int k;
    bit c, rs;

    // Reset, then acquire lock on a clean rotation.
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0001, 1'b0, 1'b1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pv",     32'(phase_valid), 32'd0);
    p = 0;
    run(4);
    check("t1_not_yet", 32'(locked), 32'd0);
    run(1);
    check("t1_lock", 32'(locked), 32'd1);
    check("t1_lock_no_tick", 32'(rev_tick), 32'd0);

    run(12);
    check("t2_revs", 32'(rev_count), 32'd3);

    // Glitch while locked, with a coincident clear that must not win.
    step(4'b0011, 1'b1, 1'b0);
    check("t3_fault", 32'(fault), 32'd1);
    check("t3_phase_held", 32'(phase), 32'd0);
    run(10);
    check("t3_sticky", 32'(fault), 32'd1);

    r = 4'b0001 << p;
    step(r, 1'b1, 1'b0);
    p = (p + 1) % W;
    check("t4_cleared", 32'(fault), 32'd0);
    run(5);
    check("t4_relock", 32'(locked), 32'd1);
    check("t4_rev_kept", 32'(rev_count), 32'd3);

    // Reversal in TRACK.
    step(4'b0001, 1'b0, 1'b1);
    p = 0;
    run(3);
    step(4'b0010, 1'b0, 1'b0);
    p = 2;
    run(3);
    check("t5_rev_nolock", 32'(locked), 32'd0);
    run(1);
    check("t5_rev_lock", 32'(locked), 32'd1);

    // Stall in TRACK.
    step(4'b0001, 1'b0, 1'b1);
    p = 0;
    run(2);
    step(4'b0010, 1'b0, 1'b0);
    p = 2;
    run(3);
    check("t5_stall_nolock", 32'(locked), 32'd0);
    run(1);
    check("t5_stall_lock", 32'(locked), 32'd1);

    // Revolution counter wrap, then reset over a held clear.
    run(20);
    r = 4'b0001 << p;
    step(r, 1'b1, 1'b1);
    check("t6_rst_locked", 32'(locked), 32'd0);
    check("t6_rst_rev", 32'(rev_count), 32'd0);
    check("t6_rst_phase", 32'(phase), 32'd0);
    p = 0;

    // Randomized mix of clean steps, glitches, jumps and stalls.
    repeat (600) begin
      rs = ($urandom_range(99) < 2);
      c  = ($urandom_range(9) == 0);
      k  = $urandom_range(99);
      if (k < 80) begin
        r = 4'b0001 << p;
        p = (p + 1) % W;
      end else if (k < 88) begin
        r = W'($urandom);
      end else if (k < 94) begin
        k = $urandom_range(W - 1);
        r = 4'b0001 << k;
        p = (k + 1) % W;
      end else begin
        r = last_r;
      end
      step(r, c, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
